// File: rtl/i2s_sample_tx_pkg.sv
// Shared audio definitions for the I2S sample transmitter.
// Includes the sample type, the channel codes and the frame-word packing.
package i2s_sample_tx_pkg;

    localparam int SAMPLE_W     = 12;
    localparam int MAX_SAMPLE_W = 32;
    localparam int MAX_FRAME_W  = 128;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    // Frame position p lives at bit (2*slot-1-p), so the word shifts out MSB first.
    function automatic logic [MAX_FRAME_W-1:0] build_frame(
        input logic [MAX_SAMPLE_W-1:0] sample,
        input int                      width,
        input int                      slot
    );
        logic [MAX_FRAME_W-1:0] frame;
        logic [6:0]             left_idx;
        logic [6:0]             right_idx;
        logic [4:0]             src_idx;
        frame = '0;
        for (int i = 0; i < MAX_SAMPLE_W; i++) begin
            left_idx  = 7'(2 * slot - 2 - i);
            right_idx = 7'(slot - 2 - i);
            src_idx   = 5'(width - 1 - i);
            if (i < width) begin
                frame[left_idx]  = sample[src_idx];
                frame[right_idx] = sample[src_idx];
            end else begin
                frame = frame;
            end
        end
        return frame;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock generator: divides clk_i down to SCLK.
// Flags, one cycle ahead of time, the cycle in which SCLK will toggle.
module i2s_clk_gen #(
    parameter int sclk_div_p = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic sclk_o,
    output logic rise_pulse_o,
    output logic fall_pulse_o
);

    localparam int CNT_W = (sclk_div_p > 1) ? $clog2(sclk_div_p) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(sclk_div_p - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_tc;

    assign w_tc         = (r_cnt == CNT_LAST);
    assign rise_pulse_o = w_tc && !r_sclk;
    assign fall_pulse_o = w_tc && r_sclk;
    assign sclk_o       = r_sclk;

    // Half-period counter; SCLK toggles on the terminal count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tc) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_sclk <= r_sclk;
        end
    end

endmodule

// File: rtl/i2s_sample_tx.sv
// Mono-to-stereo I2S transmitter: accepts one sample per frame over ready/valid.
// The accepted sample is sent MSB first on both slots with the one-bit I2S delay.
module i2s_sample_tx
    import i2s_sample_tx_pkg::*;
#(
    parameter int width_p      = 12,
    parameter int slot_width_p = 16,
    parameter int sclk_div_p   = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic signed [width_p-1:0] data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic                      sclk_o,
    output logic                      lrclk_o,
    output logic                      sdata_o,
    output logic                      underrun_o
);

    localparam int FRAME_W = 2 * slot_width_p;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(slot_width_p);

    generate
        if (slot_width_p <= width_p) begin : g_bad_slot
            $error("slot_width_p must be greater than width_p");
        end
        if (sclk_div_p < 1) begin : g_bad_div
            $error("sclk_div_p must be at least 1");
        end
        if ((width_p > MAX_SAMPLE_W) || (FRAME_W > MAX_FRAME_W)) begin : g_too_wide
            $error("sample or frame wider than the packing helper supports");
        end
    endgenerate

    logic                      w_rise_unused;
    logic                      w_fall;
    logic                      w_frame_start;
    logic                      w_xfer;
    logic [BIT_W-1:0]          w_bit_next;
    logic signed [width_p-1:0] w_src;
    logic [FRAME_W-1:0]        w_frame;

    logic signed [width_p-1:0] r_hold;
    logic                      r_hold_full;
    logic signed [width_p-1:0] r_last;
    logic [BIT_W-1:0]          r_bit;
    logic [FRAME_W-1:0]        r_shift;
    logic                      r_sdata;
    logic                      r_lrclk;
    logic                      r_underrun;

    i2s_clk_gen #(
        .sclk_div_p(sclk_div_p)
    ) u_clk_gen (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .sclk_o      (sclk_o),
        .rise_pulse_o(w_rise_unused),
        .fall_pulse_o(w_fall)
    );

    // ready_o depends only on registered state and reset, never on valid_i.
    assign ready_o       = !reset_i && !r_hold_full;
    assign w_xfer        = valid_i && ready_o;
    assign w_frame_start = w_fall && (r_bit == BIT_LAST);
    assign w_bit_next    = (r_bit == BIT_LAST) ? '0 : r_bit + BIT_W'(1);
    assign w_frame       = FRAME_W'(build_frame(MAX_SAMPLE_W'($unsigned(w_src)), width_p, slot_width_p));

    assign lrclk_o    = r_lrclk;
    assign sdata_o    = r_sdata;
    assign underrun_o = r_underrun;

    // Sample chosen for a new frame: held sample, else same-cycle bypass, else repeat.
    always_comb begin
        w_src = r_last;
        if (r_hold_full) begin
            w_src = r_hold;
        end else if (valid_i) begin
            w_src = data_i;
        end else begin
            w_src = r_last;
        end
    end

    // One-entry holding register, last-sample memory and underrun flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_last      <= '0;
            r_underrun  <= 1'b0;
        end else if (w_frame_start) begin
            r_last      <= w_src;
            r_hold_full <= 1'b0;
            r_underrun  <= !r_hold_full && !valid_i;
        end else if (w_xfer) begin
            r_hold      <= data_i;
            r_hold_full <= 1'b1;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun  <= 1'b0;
        end
    end

    // Frame serialiser, advanced on each SCLK falling edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_bit   <= BIT_LAST;
            r_shift <= '0;
            r_sdata <= 1'b0;
            r_lrclk <= CH_LEFT;
        end else if (w_fall) begin
            r_bit   <= w_bit_next;
            r_lrclk <= (w_bit_next >= BIT_RIGHT) ? CH_RIGHT : CH_LEFT;
            if (w_frame_start) begin
                r_shift <= {w_frame[FRAME_W-2:0], 1'b0};
                r_sdata <= w_frame[FRAME_W-1];
            end else begin
                r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                r_sdata <= r_shift[FRAME_W-1];
            end
        end else begin
            r_bit   <= r_bit;
            r_shift <= r_shift;
            r_sdata <= r_sdata;
            r_lrclk <= r_lrclk;
        end
    end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Scoreboard bench for i2s_sample_tx: a frame-level model pushes the expected sample
// and underrun flag at every frame start; an SDATA monitor pops and compares each frame.
module tb_i2s_sample_tx;
    import i2s_sample_tx_pkg::*;

    logic    clk = 1'b0;
    logic    reset_i;
    sample_t data_i;
    logic    valid_i;
    logic    ready_o;
    logic    sclk_o;
    logic    lrclk_o;
    logic    sdata_o;
    logic    underrun_o;

    typedef struct {
        logic [11:0] s;
        bit          u;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          frames_done = 0;
    logic [11:0] m_hold = 12'h000;
    logic [11:0] m_last = 12'h000;
    bit          m_full = 1'b0;
    bit          last_xfer = 1'b0;
    bit          inc_chk = 1'b0;
    int          hs_cnt = 0;

    i2s_sample_tx #(
        .width_p     (12),
        .slot_width_p(16),
        .sclk_div_p  (2)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .sclk_o    (sclk_o),
        .lrclk_o   (lrclk_o),
        .sdata_o   (sdata_o),
        .underrun_o(underrun_o)
    );

    // 10-unit system clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 5000) begin
                $display("FAIL wait_cyc: cycle %0d never reached, at %0d", n, cyc);
                $fatal(1, "wait bound expired");
            end
        end
    endtask

    // Cycles since reset release; frame starts fall on cycle 4 + 128*k.
    always @(posedge clk) begin
        if (reset_i) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Reference model: predicts ready_o and the sample each frame should carry.
    always @(negedge clk) begin : model
        int n;
        bit fs;
        bit xfer;
        if (reset_i) begin
            chk("ready_in_reset", {31'd0, ready_o}, 32'd0);
            m_full    = 1'b0;
            m_last    = 12'h000;
            hs_cnt    = 0;
            last_xfer = 1'b0;
            exp_q.delete();
        end else begin
            chk("ready", {31'd0, ready_o}, {31'd0, !m_full});
            xfer      = valid_i && !m_full;
            last_xfer = xfer;
            n         = cyc + 1;
            fs        = (n >= 4) && (((n - 4) % 128) == 0);
            if (fs) begin
                if (inc_chk) chk("handshakes_per_frame", hs_cnt, 32'd1);
                hs_cnt = 0;
                if (m_full) begin
                    exp_q.push_back('{s: m_hold, u: 1'b0});
                    m_last = m_hold;
                    m_full = 1'b0;
                end else if (valid_i) begin
                    exp_q.push_back('{s: data_i, u: 1'b0});
                    m_last = data_i;
                    hs_cnt = 1;
                end else begin
                    exp_q.push_back('{s: m_last, u: 1'b1});
                end
            end else if (xfer) begin
                m_hold = data_i;
                m_full = 1'b1;
                hs_cnt++;
            end
        end
    end

    // Monitor: deserialises SDATA on SCLK falls and scores each completed frame.
    always @(negedge clk) begin : monitor
        int          mb;
        int          ucnt;
        int          idle;
        bit          prev;
        logic [31:0] bits;
        logic [31:0] ew;
        exp_t        e;
        if (reset_i) begin
            mb   = 31;
            ucnt = 0;
            idle = 0;
            prev = 1'b0;
            bits = '0;
        end else begin
            if (underrun_o) ucnt++;
            if (prev && !sclk_o) begin
                idle = 0;
                mb   = (mb + 1) % 32;
                bits[31-mb] = sdata_o;
                chk("lrclk", {31'd0, lrclk_o}, (mb >= 16) ? 32'd1 : 32'd0);
                if (mb == 31) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_expect: got frame 0x%08h expected none queued", bits);
                    end else begin
                        e  = exp_q.pop_front();
                        ew = '0;
                        for (int i = 0; i < 12; i++) begin
                            ew[30-i] = e.s[11-i];
                            ew[14-i] = e.s[11-i];
                        end
                        chk("frame_word", bits, ew);
                        chk("underrun_pulses", ucnt, e.u ? 32'd1 : 32'd0);
                    end
                    frames_done++;
                    ucnt = 0;
                end
            end else begin
                idle++;
                if (idle > 8) begin
                    checks++;
                    errors++;
                    $display("FAIL sclk_timeout: got %0d cycles without fall expected <= 8", idle);
                    idle = 0;
                end
            end
            prev = sclk_o;
        end
    end

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i  = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", {31'd0, sclk_o}, 32'd0);
        chk("rst_lrclk", {31'd0, lrclk_o}, 32'd0);
        chk("rst_sdata", {31'd0, sdata_o}, 32'd0);
        chk("rst_underrun", {31'd0, underrun_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        reset_i = 1'b0;

        // SCLK phase after release, first frame start starved.
        wait_cyc(1); chk("sclk_c1", {31'd0, sclk_o}, 32'd0);
        wait_cyc(2); chk("sclk_c2", {31'd0, sclk_o}, 32'd1);
        wait_cyc(3); chk("sclk_c3", {31'd0, sclk_o}, 32'd1);
        wait_cyc(4); chk("sclk_c4", {31'd0, sclk_o}, 32'd0);
        chk("underrun_c4", {31'd0, underrun_o}, 32'd1);
        wait_cyc(5); chk("underrun_c5", {31'd0, underrun_o}, 32'd0);

        // Continuous 12'h5A3, then incrementing samples with one handshake per frame.
        wait_cyc(140);
        valid_i = 1'b1;
        data_i  = 12'h5A3;
        inc_chk = 1'b1;
        wait_cyc(260);
        chk("no_underrun_5a3", {31'd0, underrun_o}, 32'd0);
        wait_cyc(300);
        data_i = 12'h001;
        while (cyc < 780) begin
            @(posedge clk);
            #1;
            if (last_xfer) data_i = data_i + 12'h001;
        end
        valid_i = 1'b0;
        inc_chk = 1'b0;

        // Single 12'h123 then starvation.
        wait_cyc(1100);
        valid_i = 1'b1;
        data_i  = 12'h123;
        wait_cyc(1101);
        valid_i = 1'b0;
        wait_cyc(1284);
        chk("underrun_starved", {31'd0, underrun_o}, 32'd1);

        // valid_i rises exactly at a frame start with holding empty: bypass.
        wait_cyc(1539);
        valid_i = 1'b1;
        data_i  = 12'h800;
        wait_cyc(1540);
        valid_i = 1'b0;
        chk("bypass_no_underrun", {31'd0, underrun_o}, 32'd0);
        chk("bypass_ready", {31'd0, ready_o}, 32'd1);

        // Reset at b=20 with a sample waiting in holding.
        wait_cyc(1700);
        valid_i = 1'b1;
        data_i  = 12'h7FF;
        wait_cyc(1701);
        valid_i = 1'b0;
        wait_cyc(1800);
        valid_i = 1'b1;
        data_i  = 12'h3C3;
        wait_cyc(1801);
        valid_i = 1'b0;
        chk("held_ready_low", {31'd0, ready_o}, 32'd0);
        wait_cyc(1876);
        chk("b20_lrclk", {31'd0, lrclk_o}, 32'd1);
        chk("b20_sdata", {31'd0, sdata_o}, 32'd1);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_sclk", {31'd0, sclk_o}, 32'd0);
        chk("mid_rst_lrclk", {31'd0, lrclk_o}, 32'd0);
        chk("mid_rst_sdata", {31'd0, sdata_o}, 32'd0);
        chk("mid_rst_underrun", {31'd0, underrun_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        wait_cyc(4);
        chk("post_rst_underrun", {31'd0, underrun_o}, 32'd1);
        wait_cyc(270);
        chk("frames_completed", frames_done, 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
